// File: rtl/ads41_idelay_cal_if.sv
// Control/result bundle between the IDELAY calibrator and its host.
// Parameters must match the ads41_idelay_cal instance that uses the bundle.
interface ads41_idelay_cal_if #(
   parameter int NCHAN = 2,
   parameter int NBITS = 12
);
   logic                   start;
   logic [NCHAN*NBITS-1:0] d_in;
   logic [4:0]             idelay_val;
   logic [NCHAN-1:0]       idelay_ld;
   logic                   busy;
   logic                   done;
   logic [NCHAN-1:0]       fail;
   logic [5*NCHAN-1:0]     tap_out;
   logic [6*NCHAN-1:0]     eye_width;

   modport master (
      output start, d_in,
      input  idelay_val, idelay_ld, busy, done, fail, tap_out, eye_width
   );

   modport slave (
      input  start, d_in,
      output idelay_val, idelay_ld, busy, done, fail, tap_out, eye_width
   );
endinterface

// File: rtl/ads41_idelay_cal.sv
// ADS41 capture-path IDELAY calibrator: sweeps every tap per channel, finds the
// widest run of taps that sample the ADC test pattern and parks each IDELAY mid-eye.
module ads41_idelay_cal #(
   parameter int               NCHAN       = 2,
   parameter int               NBITS       = 12,
   parameter int               NTAPS       = 32,
   parameter int               SETTLE_CYC  = 16,
   parameter int               CHECK_CYC   = 64,
   parameter logic [NBITS-1:0] PATTERN     = 12'hA5C,
   parameter int               MIN_EYE     = 4,
   parameter int               DEFAULT_TAP = 11
) (
   input logic              clk,
   input logic              rst_n,
   ads41_idelay_cal_if.slave bus
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LOAD   = 3'd1;
   localparam logic [2:0] SETTLE = 3'd2;
   localparam logic [2:0] CHECK  = 3'd3;
   localparam logic [2:0] EVAL   = 3'd4;
   localparam logic [2:0] FINAL  = 3'd5;
   localparam logic [2:0] DONE   = 3'd6;

   localparam int CNTW = 16;

   logic [2:0]         state;
   logic [4:0]         tap;
   logic [1:0]         ch;
   logic [CNTW-1:0]    cnt;
   logic               tap_bad;
   logic [5:0]         cur_len;
   logic [4:0]         cur_start;
   logic [5:0]         best_len;
   logic [4:0]         best_start;
   logic [4:0]         val_q;
   logic               busy_q;
   logic               done_q;
   logic [NCHAN-1:0]   fail_q;
   logic [5*NCHAN-1:0] tap_out_q;
   logic [6*NCHAN-1:0] eye_q;

   logic [NBITS-1:0]   sample;
   logic               mismatch;
   logic [NCHAN-1:0]   ch_sel;
   logic               eye_ok;
   logic [4:0]         final_tap;
   logic [5:0]         pass_len;
   logic [4:0]         run_start;
   logic [4:0]         idelay_val_c;
   logic [NCHAN-1:0]   idelay_ld_c;

   // Mux the channel under test out of the packed sample bus.
   always_comb begin
      sample = '0;
      for (int c = 0; c < NCHAN; c++) begin
         if (ch == 2'(c)) sample = bus.d_in[c*NBITS +: NBITS];
      end
   end

   assign mismatch  = (sample != PATTERN);
   assign ch_sel    = NCHAN'(1) << ch;
   assign eye_ok    = (best_len >= 6'(MIN_EYE));
   assign final_tap = eye_ok ? (best_start + best_len[5:1]) : 5'(DEFAULT_TAP);
   assign pass_len  = cur_len + 6'd1;
   assign run_start = (cur_len == 6'd0) ? tap : cur_start;

   // NOTE: the load strobe is decoded straight from the state register, so an
   // asynchronous reset removes it in the same instant rather than a cycle later.
   always_comb begin
      idelay_ld_c  = '0;
      idelay_val_c = val_q;
      case (state)
         LOAD: begin
            idelay_ld_c  = ch_sel;
            idelay_val_c = tap;
         end
         FINAL: begin
            idelay_ld_c  = ch_sel;
            idelay_val_c = final_tap;
         end
         default: ;
      endcase
   end

   // NOTE: every register here is updated with <= so all next-state terms read
   // the values from before the clock edge, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tap        <= '0;
         ch         <= '0;
         cnt        <= '0;
         tap_bad    <= 1'b0;
         cur_len    <= '0;
         cur_start  <= '0;
         best_len   <= '0;
         best_start <= '0;
         val_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         fail_q     <= '0;
         tap_out_q  <= '0;
         eye_q      <= '0;
      end else begin
         val_q <= idelay_val_c;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state      <= LOAD;
                  tap        <= '0;
                  ch         <= '0;
                  cnt        <= '0;
                  cur_len    <= '0;
                  cur_start  <= '0;
                  best_len   <= '0;
                  best_start <= '0;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
                  fail_q     <= '0;
                  tap_out_q  <= '0;
                  eye_q      <= '0;
               end
            end

            LOAD: begin
               tap_bad <= 1'b0;
               cnt     <= '0;
               state   <= SETTLE;
            end

            SETTLE: begin
               if (cnt == CNTW'(SETTLE_CYC - 1)) begin
                  cnt   <= '0;
                  state <= CHECK;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            // A mismatch is sticky but the full comparison window always runs.
            CHECK: begin
               tap_bad <= tap_bad | mismatch;
               if (cnt == CNTW'(CHECK_CYC - 1)) begin
                  cnt   <= '0;
                  state <= EVAL;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            EVAL: begin
               if (!tap_bad) begin
                  cur_start <= run_start;
                  cur_len   <= pass_len;
                  // Strictly greater: the earliest of equal-length runs is kept.
                  if (pass_len > best_len) begin
                     best_len   <= pass_len;
                     best_start <= run_start;
                  end
               end else begin
                  cur_len <= '0;
               end
               if (tap == 5'(NTAPS - 1)) begin
                  state <= FINAL;
               end else begin
                  tap   <= tap + 5'd1;
                  state <= LOAD;
               end
            end

            FINAL: begin
               for (int c = 0; c < NCHAN; c++) begin
                  if (ch_sel[c]) begin
                     tap_out_q[c*5 +: 5] <= final_tap;
                     eye_q[c*6 +: 6]     <= best_len;
                  end
               end
               fail_q <= (fail_q & ~ch_sel) | (eye_ok ? '0 : ch_sel);
               if (ch == 2'(NCHAN - 1)) begin
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end else begin
                  ch         <= ch + 2'd1;
                  tap        <= '0;
                  cur_len    <= '0;
                  cur_start  <= '0;
                  best_len   <= '0;
                  best_start <= '0;
                  state      <= LOAD;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.idelay_val = idelay_val_c;
   assign bus.idelay_ld  = idelay_ld_c;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.fail       = fail_q;
   assign bus.tap_out    = tap_out_q;
   assign bus.eye_width  = eye_q;

endmodule

// File: tb/tb_ads41_idelay_cal.sv
// Directed bench for ads41_idelay_cal (2 channels): a behavioural ADC returns the
// test pattern only at taps inside a per-channel eye mask.
module tb_ads41_idelay_cal;

   localparam int          NCHAN = 2;
   localparam int          NBITS = 12;
   localparam logic [11:0] PAT   = 12'hA5C;
   localparam int          LAT   = 2 * (32 * (1 + 16 + 64 + 1) + 1);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ads41_idelay_cal_if #(.NCHAN(NCHAN), .NBITS(NBITS)) bus ();

   ads41_idelay_cal #(.NCHAN(NCHAN), .NBITS(NBITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // ADC model state: tap last loaded per channel, cycles since that load.
   logic [31:0] mask [NCHAN];
   logic        glitch_en;
   logic        clr_mon;
   logic [4:0]  cur_tap [NCHAN];
   int          k [NCHAN];
   int          ld_cnt [NCHAN];
   logic [NCHAN*NBITS-1:0] d_model;

   initial begin
      for (int c = 0; c < NCHAN; c++) begin
         cur_tap[c] = '0;
         k[c]       = 0;
         ld_cnt[c]  = 0;
      end
   end

   always @(posedge clk) begin
      for (int c = 0; c < NCHAN; c++) begin
         if (clr_mon) ld_cnt[c] <= 0;
         else if (bus.idelay_ld[c]) ld_cnt[c] <= ld_cnt[c] + 1;
         if (bus.idelay_ld[c]) begin
            cur_tap[c] <= bus.idelay_val;
            k[c]       <= 0;
         end else if (k[c] < 1000) begin
            k[c] <= k[c] + 1;
         end
      end
   end

   // k==79 is the last CHECK cycle after a load (16 settle + 64 check).
   always_comb begin
      logic [11:0] s;
      d_model = '0;
      for (int c = 0; c < NCHAN; c++) begin
         s = mask[c][cur_tap[c]] ? PAT : ~PAT;
         if (glitch_en && c == 0 && cur_tap[c] == 5'd10 && k[c] == 79) s = ~PAT;
         d_model[c*NBITS +: NBITS] = s;
      end
   end
   assign bus.d_in = d_model;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic run_cal(input string tag, input bit extra_start);
      int  cyc;
      bit  done_seen;
      clr_mon = 1'b1;
      @(posedge clk); #1;
      clr_mon   = 1'b0;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check({tag, "_busy_after_start"}, 32'(bus.busy), 32'd1);
      check({tag, "_done_cleared"}, 32'(bus.done), 32'd0);
      cyc       = 0;
      done_seen = 1'b0;
      while (!done_seen && cyc < 20000) begin
         @(posedge clk); #1;
         cyc++;
         bus.start = extra_start && (cyc == 100);
         done_seen = bus.done;
      end
      bus.start = 1'b0;
      check({tag, "_done_seen"}, 32'(done_seen), 32'd1);
      check({tag, "_latency"}, 32'(cyc), 32'(LAT));
      check({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic check_ch(input string tag, input int c, input logic [4:0] tap,
                           input logic [5:0] eye, input logic f);
      check({tag, "_tap_out"}, 32'(bus.tap_out[c*5 +: 5]), 32'(tap));
      check({tag, "_eye_width"}, 32'(bus.eye_width[c*6 +: 6]), 32'(eye));
      check({tag, "_fail"}, 32'(bus.fail[c]), 32'(f));
      check({tag, "_final_ld_val"}, 32'(cur_tap[c]), 32'(tap));
      check({tag, "_ld_pulses"}, 32'(ld_cnt[c]), 32'd33);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_idelay_val"}, 32'(bus.idelay_val), 32'd0);
      check({tag, "_idelay_ld"}, 32'(bus.idelay_ld), 32'd0);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_done"}, 32'(bus.done), 32'd0);
      check({tag, "_fail"}, 32'(bus.fail), 32'd0);
      check({tag, "_tap_out"}, 32'(bus.tap_out), 32'd0);
      check({tag, "_eye_width"}, 32'(bus.eye_width), 32'd0);
   endtask

   initial begin
      int  w;
      bit  ld_seen;
      bus.start = 1'b0;
      glitch_en = 1'b0;
      clr_mon   = 1'b0;
      mask[0]   = '0;
      mask[1]   = '0;

      // Reset state and idle wait after release.
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_done", 32'(bus.done), 32'd0);

      // Wide eye 8..19 on ch0; two equal runs 2..6 / 20..24 on ch1.
      mask[0] = 32'h000F_FF00;
      mask[1] = 32'h01F0_007C;
      run_cal("A", 1'b0);
      check_ch("A_ch0", 0, 5'd14, 6'd12, 1'b0);
      check_ch("A_ch1", 1, 5'd4, 6'd5, 1'b0);
      check("A_val_hold", 32'(bus.idelay_val), 32'd4);
      check("A_ld_idle", 32'(bus.idelay_ld), 32'd0);

      // Run touching tap 31 on ch0; never-matching data on ch1.
      mask[0] = 32'hF800_0000;
      mask[1] = 32'h0000_0000;
      run_cal("B", 1'b0);
      check_ch("B_ch0", 0, 5'd29, 6'd5, 1'b0);
      check_ch("B_ch1", 1, 5'd11, 6'd0, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      check("B_done_held", 32'(bus.done), 32'd1);
      check("B_val_hold", 32'(bus.idelay_val), 32'd11);

      // Last-cycle glitch at tap 10 splits 5..15; ch1 eye exactly MIN_EYE wide.
      mask[0]   = 32'h0000_FFE0;
      mask[1]   = 32'h0000_000F;
      glitch_en = 1'b1;
      run_cal("C", 1'b0);
      glitch_en = 1'b0;
      check_ch("C_ch0", 0, 5'd7, 6'd5, 1'b0);
      check_ch("C_ch1", 1, 5'd2, 6'd4, 1'b0);

      // Abort during ch1 SETTLE with reset.
      mask[0] = 32'hC000_0000;
      mask[1] = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      w       = 0;
      ld_seen = 1'b0;
      while (!ld_seen && w < 10000) begin
         @(posedge clk); #1;
         w++;
         ld_seen = bus.idelay_ld[1];
      end
      check("D_ch1_load_seen", 32'(ld_seen), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      check("D_pre_busy", 32'(bus.busy), 32'd1);
      check("D_pre_fail", 32'(bus.fail), 32'b01);
      check("D_pre_tap_out", 32'(bus.tap_out), 32'd11);
      check("D_pre_eye", 32'(bus.eye_width), 32'd2);
      rst_n = 1'b0;
      #1;
      check_zero("D_reset");
      ld_seen = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         ld_seen = ld_seen | (|bus.idelay_ld);
      end
      check("D_no_ld_in_reset", 32'(ld_seen), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("D_idle_after_release", 32'(bus.busy), 32'd0);

      // Recalibrate from tap 0 with an extra start while busy.
      mask[0] = 32'hFFFF_FFFF;
      mask[1] = 32'h7000_0000;
      run_cal("E", 1'b1);
      check_ch("E_ch0", 0, 5'd16, 6'd32, 1'b0);
      check_ch("E_ch1", 1, 5'd11, 6'd3, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
